// File: rtl/swervolf_sw_debounce_if.sv
// Switch conditioning bundle: raw switch levels and event clears in, debounced levels and events out.
interface swervolf_sw_debounce_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] i_sw;
    logic [WIDTH-1:0] i_clr;
    logic [WIDTH-1:0] o_sw;
    logic [WIDTH-1:0] o_changed;
    logic [WIDTH-1:0] o_event;
    logic             o_irq;

    modport master (
        output i_sw,
        output i_clr,
        input  o_sw,
        input  o_changed,
        input  o_event,
        input  o_irq
    );

    modport slave (
        input  i_sw,
        input  i_clr,
        output o_sw,
        output o_changed,
        output o_event,
        output o_irq
    );
endinterface

// File: rtl/swervolf_sw_debounce.sv
// Synchronises and debounces board slide switches, with sticky per-bit change events and a summary irq.
// Acceptance latency SYNC_STAGES+(STABLE_TICKS-1)*TICK_DIV+1 .. SYNC_STAGES+STABLE_TICKS*TICK_DIV cycles; no backpressure.
module swervolf_sw_debounce #(
    parameter int               WIDTH        = 16,
    parameter int               SYNC_STAGES  = 2,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    swervolf_sw_debounce_if.slave sw
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [PW-1:0]    p;
    logic             tick;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] sw_q;
    logic [WIDTH-1:0] changed_q;
    logic [WIDTH-1:0] event_q;

    // Plain flop chain: nothing may sit between stages or metastability resolution suffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= sw.i_sw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (tick) begin
            p <= '0;
        end else begin
            p <= p + PW'(1);
        end
    end

    assign tick = (p == P_LAST);

    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s[i] != sw_q[i]) && tick && (cnt[i] == C_LAST);
        end
    end

    // Any cycle where the synced level matches the output restarts qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == sw_q[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= accept[i] ? '0 : cnt[i] + CW'(1);
                end
            end
        end
    end

    // accept implies s differs from sw_q, so toggling takes the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q      <= RESET_VAL;
            changed_q <= '0;
            event_q   <= '0;
        end else begin
            sw_q      <= sw_q ^ accept;
            changed_q <= accept;
            event_q   <= (event_q & ~sw.i_clr) | accept;
        end
    end

    assign sw.o_sw      = sw_q;
    assign sw.o_changed = changed_q;
    assign sw.o_event   = event_q;
    assign sw.o_irq     = |event_q;

endmodule

// File: tb/tb_swervolf_sw_debounce.sv
// Directed bench for the switch debouncer with a short tick (TICK_DIV=4, STABLE_TICKS=3).
module tb_swervolf_sw_debounce;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total;

    swervolf_sw_debounce_if #(.WIDTH(16)) swi ();

    swervolf_sw_debounce #(
        .WIDTH       (16),
        .SYNC_STAGES (2),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .RESET_VAL   (16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw (swi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        int lat;
        int pulses;
        int chg_any;
        bit seen;
        bit pend;

        pass_cnt = 0;
        total    = 0;
        rst      = 1'b1;
        swi.i_sw  = '0;
        swi.i_clr = '0;
        #1;
        chk("rst_async_state", {swi.o_sw, swi.o_changed[14:0], swi.o_irq}, 32'h0);
        repeat (3) step();
        chk("rst_held_event", {16'h0, swi.o_event}, 32'h0);
        rst = 1'b0;

        // Quiet inputs after reset: everything stays at zero.
        for (int n = 0; n < 50; n++) begin
            step();
            chk("idle_zero", {swi.o_sw, swi.o_changed[14:0], swi.o_irq}, 32'h0);
        end
        chk("idle_event", {16'h0, swi.o_event}, 32'h0);

        // Single bit rising edge.
        swi.i_sw[3] = 1'b1;
        seen = 0; lat = 0; pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (swi.o_changed[3]) pulses++;
            if (!seen && swi.o_sw[3]) begin
                seen = 1;
                lat  = n;
                chk("t2_changed_with_sw", {31'h0, swi.o_changed[3]}, 32'h1);
                chk("t2_event", {16'h0, swi.o_event}, 32'h0008);
                chk("t2_irq", {31'h0, swi.o_irq}, 32'h1);
            end
        end
        chk("t2_latency_in_11_14", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);
        chk("t2_pulse_count", pulses, 1);
        chk("t2_sw", {16'h0, swi.o_sw}, 32'h0008);
        swi.i_clr = 16'h0008;
        step();
        swi.i_clr = '0;
        chk("t2_clr_event", {16'h0, swi.o_event}, 32'h0);
        chk("t2_clr_irq", {31'h0, swi.o_irq}, 32'h0);

        // Bouncing bit 0: 5-cycle pulses can never qualify.
        chg_any = 0;
        for (int t = 0; t < 12; t++) begin
            swi.i_sw[0] = ~swi.i_sw[0];
            for (int k = 0; k < 5; k++) begin
                step();
                if (swi.o_changed != 16'h0) chg_any++;
            end
        end
        chk("t3_no_change_bouncing", chg_any, 0);
        chk("t3_sw_hold", {16'h0, swi.o_sw}, 32'h0008);
        swi.i_sw[0] = 1'b1;
        lat = 0; pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (swi.o_changed[0]) begin
                pulses++;
                lat = n;
            end
        end
        chk("t3_pulse_count", pulses, 1);
        chk("t3_latency_in_11_14", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);
        swi.i_clr = '1;
        step();
        swi.i_clr = '0;

        // Clear held across the acceptance: set must win, then clear takes effect.
        swi.i_sw[5]  = 1'b1;
        swi.i_clr[5] = 1'b1;
        pulses = 0; pend = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (pend) begin
                chk("t4_clear_after_set", {31'h0, swi.o_event[5]}, 32'h0);
                pend = 0;
            end
            if (swi.o_changed[5]) begin
                chk("t4_set_wins", {31'h0, swi.o_event[5]}, 32'h1);
                pulses++;
                pend = 1;
            end
        end
        chk("t4_pulse_count", pulses, 1);
        swi.i_clr = '0;

        // Return to zero, then all bits rise together.
        swi.i_sw = '0;
        repeat (20) step();
        swi.i_clr = '1;
        step();
        swi.i_clr = '0;
        chk("t5_pre_sw", {16'h0, swi.o_sw}, 32'h0);
        chk("t5_pre_event", {16'h0, swi.o_event}, 32'h0);
        swi.i_sw = '1;
        seen = 0; lat = 0; pend = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (pend) begin
                chk("t5_changed_one_cycle", {16'h0, swi.o_changed}, 32'h0);
                pend = 0;
            end
            if (!seen && swi.o_changed != 16'h0) begin
                seen = 1;
                lat  = n;
                pend = 1;
                chk("t5_changed_all", {16'h0, swi.o_changed}, 32'hFFFF);
                chk("t5_sw_all", {16'h0, swi.o_sw}, 32'hFFFF);
                chk("t5_event_all", {16'h0, swi.o_event}, 32'hFFFF);
            end
        end
        chk("t5_latency_in_11_14", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);

        // Reset in the middle of qualifying bit 7 (two ticks in after 10 cycles).
        swi.i_sw = 16'hFF7F;
        repeat (20) step();
        chk("t6_pre_sw", {16'h0, swi.o_sw}, 32'hFF7F);
        swi.i_sw[7] = 1'b1;
        repeat (10) step();
        chk("t6_not_yet", {16'h0, swi.o_sw}, 32'hFF7F);
        rst = 1'b1;
        #1;
        chk("t6_rst_sw", {16'h0, swi.o_sw}, 32'h0);
        chk("t6_rst_event", {16'h0, swi.o_event}, 32'h0);
        chk("t6_rst_changed", {16'h0, swi.o_changed}, 32'h0);
        chk("t6_rst_irq", {31'h0, swi.o_irq}, 32'h0);
        repeat (2) step();
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            chk("t6_bit7_timing", {31'h0, swi.o_sw[7]}, {31'h0, (n >= 12)});
            if (n == 12) begin
                chk("t6_sw_all", {16'h0, swi.o_sw}, 32'hFFFF);
                chk("t6_changed_all", {16'h0, swi.o_changed}, 32'hFFFF);
                chk("t6_event_all", {16'h0, swi.o_event}, 32'hFFFF);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
